// File: rtl/fb_scanout_reader.sv
// Framebuffer scanout: display timing -> front-buffer read address, RGB332->RGB444 with 2x upscale.
// Latency RD_LAT+2 cycles for colour and delayed syncs; never stalls; buffer swap deferred to vsync fall.
module fb_scanout_reader #(
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int ADDR_W = 18,
  parameter int RD_LAT = 1
) (
  input  logic              pixel_clk,
  input  logic              arstn,
  input  logic [9:0]        drawX,
  input  logic [9:0]        drawY,
  input  logic              vde,
  input  logic              hsync,
  input  logic              vsync,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [7:0]        fb_rd_data,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              front_sel,
  output logic [15:0]       frame_cnt,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              vde_o
);

  localparam int L = RD_LAT + 2;
  localparam logic [ADDR_W-1:0] BUF1_BASE = ADDR_W'(FB_W * FB_H);

  typedef enum logic {
    SHOW,
    PENDING
  } swap_state_t;

  swap_state_t state, state_nxt;

  logic              vsync_d;
  logic              vs_fall;
  logic              front_sel_nxt;
  logic              swap_ack_nxt;
  logic [15:0]       frame_cnt_q;
  logic [ADDR_W-1:0] fx_ext;
  logic [ADDR_W-1:0] fy_ext;
  logic [ADDR_W-1:0] row_off;
  logic [ADDR_W-1:0] pix_addr;
  logic [L-1:0]      hs_pipe;
  logic [L-1:0]      vs_pipe;
  logic [L-1:0]      de_pipe;
  logic              unused_lsbs;

  // The low coordinate bits only select the duplicate of a 2x2 upscaled pixel.
  assign unused_lsbs = drawX[0] ^ drawY[0];

  assign fx_ext = ADDR_W'(drawX[9:1]);
  assign fy_ext = ADDR_W'(drawY[9:1]);

  generate
    if (FB_W == 320) begin : g_row_shift
      assign row_off = (fy_ext << 8) + (fy_ext << 6);
    end else begin : g_row_mul
      assign row_off = fy_ext * ADDR_W'(FB_W);
    end
  endgenerate

  assign pix_addr = (front_sel ? BUF1_BASE : '0) + row_off + fx_ext;

  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      fb_rd_en   <= 1'b0;
      fb_rd_addr <= '0;
    end else begin
      fb_rd_en <= vde;
      if (vde) begin
        fb_rd_addr <= pix_addr;
      end
    end
  end

  // Syncs idle high; stage L-2 of the enable pipe lines up with fb_rd_data.
  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      hs_pipe <= '1;
      vs_pipe <= '1;
      de_pipe <= '0;
    end else begin
      hs_pipe <= {hs_pipe[L-2:0], hsync};
      vs_pipe <= {vs_pipe[L-2:0], vsync};
      de_pipe <= {de_pipe[L-2:0], vde};
    end
  end

  assign hsync_o = hs_pipe[L-1];
  assign vsync_o = vs_pipe[L-1];
  assign vde_o   = de_pipe[L-1];

  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      red   <= 4'h0;
      green <= 4'h0;
      blue  <= 4'h0;
    end else if (de_pipe[L-2]) begin
      red   <= {fb_rd_data[7:5], fb_rd_data[7]};
      green <= {fb_rd_data[4:2], fb_rd_data[4]};
      blue  <= {fb_rd_data[1:0], fb_rd_data[1:0]};
    end else begin
      red   <= 4'h0;
      green <= 4'h0;
      blue  <= 4'h0;
    end
  end

  assign vs_fall = vsync_d & ~vsync;

  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      state <= SHOW;
    end else begin
      state <= state_nxt;
    end
  end

  // A request seen together with the ack edge is folded into that swap.
  always_comb begin
    state_nxt     = state;
    front_sel_nxt = front_sel;
    swap_ack_nxt  = 1'b0;
    case (state)
      SHOW: begin
        if (swap_req) begin
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (vs_fall) begin
          front_sel_nxt = ~front_sel;
          swap_ack_nxt  = 1'b1;
          state_nxt     = SHOW;
        end
      end
      default: state_nxt = SHOW;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      vsync_d     <= 1'b1;
      front_sel   <= 1'b0;
      swap_ack    <= 1'b0;
      frame_cnt_q <= 16'h0000;
    end else begin
      vsync_d   <= vsync;
      front_sel <= front_sel_nxt;
      swap_ack  <= swap_ack_nxt;
      if (vs_fall) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Bench for fb_scanout_reader: table-driven address/colour vectors, a per-cycle
// scoreboard of delayed outputs, and hand-written swap/reset/wrap sequences.
module tb_fb_scanout_reader;

  localparam int RD_LAT = 1;
  localparam int L      = RD_LAT + 2;
  localparam int ADDR_W = 18;

  logic              pixel_clk = 1'b0;
  logic              arstn     = 1'b0;
  logic [9:0]        drawX     = '0;
  logic [9:0]        drawY     = '0;
  logic              vde       = 1'b0;
  logic              hsync     = 1'b1;
  logic              vsync     = 1'b1;
  logic              swap_req  = 1'b0;
  logic [7:0]        fb_rd_data = 8'h00;
  logic              fb_rd_en;
  logic [ADDR_W-1:0] fb_rd_addr;
  logic              swap_ack;
  logic              front_sel;
  logic [15:0]       frame_cnt;
  logic [3:0]        red, green, blue;
  logic              hsync_o, vsync_o, vde_o;

  fb_scanout_reader #(.FB_W(320), .FB_H(240), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .pixel_clk (pixel_clk),
    .arstn     (arstn),
    .drawX     (drawX),
    .drawY     (drawY),
    .vde       (vde),
    .hsync     (hsync),
    .vsync     (vsync),
    .fb_rd_en  (fb_rd_en),
    .fb_rd_addr(fb_rd_addr),
    .fb_rd_data(fb_rd_data),
    .swap_req  (swap_req),
    .swap_ack  (swap_ack),
    .front_sel (front_sel),
    .frame_cnt (frame_cnt),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .hsync_o   (hsync_o),
    .vsync_o   (vsync_o),
    .vde_o     (vde_o)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Framebuffer model: either a constant pixel or an address-derived pattern.
  logic       bram_use_const = 1'b0;
  logic [7:0] bram_const     = 8'h00;

  function automatic logic [7:0] bram_f(input logic [ADDR_W-1:0] a);
    return bram_use_const ? bram_const : (a[7:0] ^ a[15:8]);
  endfunction

  always @(posedge pixel_clk) fb_rd_data <= bram_f(fb_rd_addr);

  function automatic logic [11:0] expand(input logic [7:0] p);
    return {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0]};
  endfunction

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } out_t;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       fs;
    int         addr;
  } avec_t;

  typedef struct {
    logic [7:0]  p;
    logic [11:0] rgb;
  } cvec_t;

  out_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Model of DUT registers as seen after the next active edge.
  logic [ADDR_W-1:0] m_addr;
  logic              m_en, m_fs, m_ack, m_vsd, m_pend;
  logic [15:0]       m_fc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    out_t r;
    m_addr = '0; m_en = 1'b0; m_fs = 1'b0; m_ack = 1'b0;
    m_vsd = 1'b1; m_pend = 1'b0; m_fc = 16'h0;
    exp_q.delete();
    r.de = 1'b0; r.hs = 1'b1; r.vs = 1'b1; r.rgb = 12'h000;
    repeat (L - 1) exp_q.push_back(r);
  endtask

  // One cycle: drive inputs at a falling edge, predict, then compare at the next falling edge.
  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic de,
                      input logic hs, input logic vs, input logic req);
    out_t e;
    logic edge_seen;
    int   a;
    drawX = x; drawY = y; vde = de; hsync = hs; vsync = vs; swap_req = req;
    edge_seen = m_vsd && !vs;
    m_en = de;
    if (de) begin
      a = (m_fs ? 76800 : 0) + (int'(y) / 2) * 320 + int'(x) / 2;
      m_addr = ADDR_W'(a);
    end
    m_ack = 1'b0;
    if (m_pend && edge_seen) begin
      m_fs = ~m_fs; m_ack = 1'b1; m_pend = 1'b0;
    end else if (!m_pend && req) begin
      m_pend = 1'b1;
    end
    if (edge_seen) m_fc = m_fc + 16'd1;
    m_vsd = vs;
    e.de = de; e.hs = hs; e.vs = vs;
    e.rgb = de ? expand(bram_f(m_addr)) : 12'h000;
    exp_q.push_back(e);
    @(negedge pixel_clk);
    e = exp_q.pop_front();
    chk("vde_o", 32'(vde_o), 32'(e.de));
    chk("hsync_o", 32'(hsync_o), 32'(e.hs));
    chk("vsync_o", 32'(vsync_o), 32'(e.vs));
    chk("rgb", 32'({red, green, blue}), 32'(e.rgb));
    chk("fb_rd_en", 32'(fb_rd_en), 32'(m_en));
    chk("fb_rd_addr", 32'(fb_rd_addr), 32'(m_addr));
    chk("front_sel", 32'(front_sel), 32'(m_fs));
    chk("swap_ack", 32'(swap_ack), 32'(m_ack));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
  endtask

  task automatic idle(input int n);
    repeat (n) step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    arstn = 1'b0; vde = 1'b0; hsync = 1'b1; vsync = 1'b1; swap_req = 1'b0;
    @(negedge pixel_clk);
    chk("rst_front_sel", 32'(front_sel), 32'd0);
    chk("rst_swap_ack", 32'(swap_ack), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_rgb", 32'({red, green, blue}), 32'd0);
    chk("rst_hsync_o", 32'(hsync_o), 32'd1);
    chk("rst_vsync_o", 32'(vsync_o), 32'd1);
    chk("rst_vde_o", 32'(vde_o), 32'd0);
    chk("rst_fb_rd_en", 32'(fb_rd_en), 32'd0);
    chk("rst_fb_rd_addr", 32'(fb_rd_addr), 32'd0);
    arstn = 1'b1;
    model_reset();
  endtask

  // Miniature frame: 6 active cycles, blanking, vsync low on steps 9-10.
  task automatic run_frame(input logic [11:0] req_mask, output int acks, output logic fs8);
    acks = 0;
    fs8  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(10'(i * 53), 10'(i * 7 + 100), i < 6, 1'b1, !(i == 9 || i == 10), req_mask[i]);
      if (swap_ack) acks++;
      if (i == 8) fs8 = front_sel;
    end
  endtask

  task automatic apply_addr_tab(input avec_t tab[6], input logic phase);
    for (int i = 0; i < 6; i++) begin
      if (tab[i].fs == phase) begin
        step(tab[i].x, tab[i].y, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("addr_tab", 32'(fb_rd_addr), 32'(tab[i].addr));
      end
    end
    idle(3);
  endtask

  initial begin
    avec_t atab[6];
    cvec_t ctab[4];
    int    acks;
    logic  fs8;
    logic  vo[5];
    logic  ho[5];
    logic  so[5];
    logic [11:0] co[5];

    atab[0] = '{x: 10'd0,   y: 10'd0,   fs: 1'b0, addr: 0};
    atab[1] = '{x: 10'd639, y: 10'd479, fs: 1'b0, addr: 76799};
    atab[2] = '{x: 10'd281, y: 10'd41,  fs: 1'b0, addr: 6540};
    atab[3] = '{x: 10'd0,   y: 10'd0,   fs: 1'b1, addr: 76800};
    atab[4] = '{x: 10'd639, y: 10'd479, fs: 1'b1, addr: 153599};
    atab[5] = '{x: 10'd281, y: 10'd41,  fs: 1'b1, addr: 83340};
    ctab[0] = '{p: 8'hE0, rgb: 12'hF00};
    ctab[1] = '{p: 8'h1C, rgb: 12'h0F0};
    ctab[2] = '{p: 8'h03, rgb: 12'h00F};
    ctab[3] = '{p: 8'hC3, rgb: 12'hD0F};

    do_reset();
    apply_addr_tab(atab, 1'b0);

    repeat (3) run_frame(12'h000, acks, fs8);
    chk("frame_cnt_3", 32'(frame_cnt), 32'd3);

    run_frame(12'h004, acks, fs8);
    chk("midframe_fs_hold", 32'(fs8), 32'd0);
    chk("midframe_acks", 32'(acks), 32'd1);
    chk("midframe_fs_after", 32'(front_sel), 32'd1);

    apply_addr_tab(atab, 1'b1);

    run_frame(12'h02A, acks, fs8);
    chk("triple_req_acks", 32'(acks), 32'd1);
    chk("triple_req_fs", 32'(front_sel), 32'd0);

    run_frame(12'h200, acks, fs8);
    chk("coincident_acks", 32'(acks), 32'd0);
    chk("coincident_fs", 32'(front_sel), 32'd0);
    run_frame(12'h000, acks, fs8);
    chk("coincident_next_acks", 32'(acks), 32'd1);
    chk("coincident_next_fs", 32'(front_sel), 32'd1);

    run_frame(12'h204, acks, fs8);
    chk("ack_absorb_acks", 32'(acks), 32'd1);
    chk("ack_absorb_fs", 32'(front_sel), 32'd0);
    run_frame(12'h000, acks, fs8);
    chk("ack_absorb_next_acks", 32'(acks), 32'd0);
    chk("ack_absorb_next_fs", 32'(front_sel), 32'd0);

    // Colour expansion and 3-cycle alignment of vde/hsync/vsync with RGB.
    for (int c = 0; c < 4; c++) begin
      idle(3);
      bram_use_const = 1'b1;
      bram_const     = ctab[c].p;
      for (int k = 0; k < 5; k++) begin
        step(10'(k * 10), 10'd20, 1'b1, k != 0, k != 0, 1'b0);
        vo[k] = vde_o; ho[k] = hsync_o; so[k] = vsync_o; co[k] = {red, green, blue};
      end
      chk("lat_vde_t1", 32'(vo[1]), 32'd0);
      chk("lat_vde_t3", 32'(vo[2]), 32'd1);
      chk("lat_hs_t2", 32'(ho[1]), 32'd1);
      chk("lat_hs_t3", 32'(ho[2]), 32'd0);
      chk("lat_hs_t4", 32'(ho[3]), 32'd1);
      chk("lat_vs_t3", 32'(so[2]), 32'd0);
      chk("lat_rgb_t2", 32'(co[1]), 32'd0);
      chk("colour_tab", 32'(co[2]), 32'(ctab[c].rgb));
    end
    idle(3);

    bram_const = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      step(10'd100, 10'd100, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("blank_rgb", 32'({red, green, blue}), 32'd0);
      chk("blank_rd_en", 32'(fb_rd_en), 32'd0);
    end
    idle(3);
    bram_use_const = 1'b0;

    run_frame(12'h004, acks, fs8);
    chk("pre_reset_fs", 32'(front_sel), 32'd1);
    step(10'd40, 10'd40, 1'b1, 1'b1, 1'b1, 1'b1);
    step(10'd42, 10'd40, 1'b1, 1'b0, 1'b1, 1'b0);
    do_reset();
    run_frame(12'h000, acks, fs8);
    chk("post_reset_acks", 32'(acks), 32'd0);
    chk("post_reset_fs", 32'(front_sel), 32'd0);
    chk("post_reset_frames", 32'(frame_cnt), 32'd1);

    idle(2);
    force dut.frame_cnt_q = 16'hFFFF;
    m_fc = 16'hFFFF;
    idle(1);
    release dut.frame_cnt_q;
    idle(1);
    chk("wrap_pre", 32'(frame_cnt), 32'h0000FFFF);
    step(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("wrap_zero", 32'(frame_cnt), 32'd0);
    step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
